// File: rtl/spi_mstr16_if.sv
// Command/response and serial-pin bundle between the inertial interface,
// the SPI master and the sensor.
interface spi_mstr16_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  modport master (
    input  wrt, cmd, MISO,
    output done, rd_data, SS_n, SCLK, MOSI
  );

  modport slave (
    output wrt, cmd, MISO,
    input  done, rd_data, SS_n, SCLK, MOSI
  );
endinterface

// File: rtl/spi_mstr16.sv
// 16-bit mode-3 SPI master, SCLK = clk/32, full-duplex shift of one command
// word with a sticky done flag for the polling inertial interface.
//
// state | meaning
// IDLE  | SS_n high, SCLK high, waiting for wrt
// FRONT | SS_n low, SCLK high, setup time before the first SCLK fall
// SHIFT | 16 rise-sample / fall-shift SCLK periods
// BACK  | SCLK held high after the 16th rise, final shift then release SS_n
module spi_mstr16 (
  input  logic         clk,
  input  logic         rst_n,
  spi_mstr16_if.master bus
);

  typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;

  // Preload puts the first SCLK fall 9 clocks after the accepting edge.
  localparam logic [4:0] DIV_LOAD = 5'b10111;

  state_t      state, nxt_state;
  logic [4:0]  div;
  logic [15:0] shft;
  logic        smpl;
  logic [4:0]  bit_cnt;
  logic        ss_n_q;
  logic        done_q;

  logic start, inc_div, smpl_en, shift_en, finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    start     = 1'b0;
    inc_div   = 1'b0;
    smpl_en   = 1'b0;
    shift_en  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.wrt) begin
          start     = 1'b1;
          nxt_state = FRONT;
        end
      end
      FRONT: begin
        inc_div = 1'b1;
        if (div == 5'b11111) nxt_state = SHIFT;
      end
      SHIFT: begin
        inc_div = 1'b1;
        if (div == 5'b01111) begin
          smpl_en = 1'b1;
          if (bit_cnt == 5'd15) nxt_state = BACK;
        end
        if (div == 5'b11111) shift_en = 1'b1;
      end
      BACK: begin
        inc_div = 1'b1;
        if (div == 5'b11111) begin
          shift_en  = 1'b1;
          finish    = 1'b1;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                div <= DIV_LOAD;
    else if (start || finish)  div <= DIV_LOAD;
    else if (inc_div)          div <= div + 5'd1;
  end

  // The last shift in BACK pushes in the bit sampled at the 16th rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        shft <= 16'h0000;
    else if (start)    shft <= bus.cmd;
    else if (shift_en) shft <= {shft[14:0], smpl};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       smpl <= 1'b0;
    else if (smpl_en) smpl <= bus.MISO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       bit_cnt <= 5'd0;
    else if (start)   bit_cnt <= 5'd0;
    else if (smpl_en) bit_cnt <= bit_cnt + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_q <= 1'b1;
      done_q <= 1'b0;
    end else if (start) begin
      ss_n_q <= 1'b0;
      done_q <= 1'b0;
    end else if (finish) begin
      ss_n_q <= 1'b1;
      done_q <= 1'b1;
    end
  end

  assign bus.SCLK    = div[4];
  assign bus.MOSI    = shft[15];
  assign bus.rd_data = shft;
  assign bus.SS_n    = ss_n_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_spi_mstr16.sv
// Directed bench for spi_mstr16: loopback and mode-3 slave data, SCLK/SS_n
// timing monitor, wrt-while-busy, async reset and done persistence.
module tb_spi_mstr16;

  logic clk;
  logic rst_n;
  spi_mstr16_if bus();

  spi_mstr16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, obs, obs, exp, exp);
    end
  endtask

  // MISO source: loopback of MOSI or a mode-3 slave shifting on SCLK falls
  logic        loop = 1'b1;
  logic [15:0] slv_tx = 16'h0000;
  logic [15:0] slv_sr = 16'h0000;
  logic [15:0] slv_rx = 16'h0000;
  logic        seen_rise = 1'b0;

  assign bus.MISO = loop ? bus.MOSI : slv_sr[15];

  always @(negedge bus.SS_n) begin
    slv_sr    = slv_tx;
    slv_rx    = 16'h0000;
    seen_rise = 1'b0;
  end
  always @(posedge bus.SCLK) if (bus.SS_n === 1'b0) begin
    slv_rx    = {slv_rx[14:0], bus.MOSI};
    seen_rise = 1'b1;
  end
  always @(negedge bus.SCLK) if (bus.SS_n === 1'b0 && seen_rise)
    slv_sr = {slv_sr[14:0], 1'b0};

  // SCLK / SS_n timing monitor, sampled on falling clk
  int   cyc = 0;
  int   t_ss = 0, t_rise = 0, t_fall = 0, rises = 0, done_rises = 0;
  logic first_fall = 1'b0;
  logic prev_sclk = 1'b1, prev_ss = 1'b1, prev_mosi = 1'b0, prev_done = 1'b0;
  logic idle_bad = 1'b0, mosi_bad = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      rises      = 0;
      first_fall = 1'b0;
      prev_sclk  = 1'b1;
      prev_ss    = 1'b1;
      prev_mosi  = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_ss && !bus.SS_n) begin
        t_ss       = cyc;
        rises      = 0;
        first_fall = 1'b1;
      end
      if (bus.SS_n && !bus.SCLK) idle_bad = 1'b1;
      if (prev_sclk && !bus.SCLK) begin
        if (first_fall) begin
          chk("setup", 32'(cyc - t_ss), 32'd9);
          first_fall = 1'b0;
        end else begin
          chk("high_phase", 32'(cyc - t_rise), 32'd16);
        end
        t_fall = cyc;
      end
      if (!prev_sclk && bus.SCLK && !bus.SS_n) begin
        chk("low_phase", 32'(cyc - t_fall), 32'd16);
        rises++;
        t_rise = cyc;
        if (bus.MOSI !== prev_mosi) mosi_bad = 1'b1;
      end
      if (!prev_ss && bus.SS_n) begin
        chk("rise_count", 32'(rises), 32'd16);
        chk("hold", 32'(cyc - t_rise), 32'd16);
      end
      if (!prev_done && bus.done) done_rises++;
      prev_sclk = bus.SCLK;
      prev_ss   = bus.SS_n;
      prev_mosi = bus.MOSI;
      prev_done = bus.done;
    end
  end

  // Called at a falling clk; the next rising edge is the accepting edge E.
  task automatic send(input logic [15:0] c);
    bus.wrt = 1'b1;
    bus.cmd = c;
    @(negedge clk);
    bus.wrt = 1'b0;
    bus.cmd = 16'($urandom);
    chk("ss_fall", 32'(bus.SS_n), 32'd0);
    chk("done_clr", 32'(bus.done), 32'd0);
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!bus.done && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input logic [15:0] c, input logic [15:0] exp_rd, input string tag);
    int lat;
    send(c);
    wait_done(0, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd521);
    chk({tag, "_rd"}, 32'(bus.rd_data), 32'(exp_rd));
    chk({tag, "_ss"}, 32'(bus.SS_n), 32'd1);
  endtask

  initial begin
    int lat;
    int dr0;
    rst_n   = 1'b0;
    bus.wrt = 1'b0;
    bus.cmd = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_ss", 32'(bus.SS_n), 32'd1);
    chk("rst_sclk", 32'(bus.SCLK), 32'd1);
    chk("rst_mosi", 32'(bus.MOSI), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rd", 32'(bus.rd_data), 32'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    run(16'h0D02, 16'h0D02, "loop");

    loop   = 1'b0;
    slv_tx = 16'hA55A;
    run(16'h8F00, 16'hA55A, "slave");
    chk("slave_rx", 32'(slv_rx), 32'h8F00);
    loop = 1'b1;

    // back-to-back at the earliest accepting edge
    run(16'h1234, 16'h1234, "b2b0");
    run(16'hFFFF, 16'hFFFF, "b2b1");
    run(16'h0000, 16'h0000, "b2b2");
    run(16'h8001, 16'h8001, "b2b3");

    // wrt on the edge that returns to IDLE must be dropped
    send(16'h3C3C);
    repeat (520) @(negedge clk);
    chk("pre_done", 32'(bus.done), 32'd0);
    bus.wrt = 1'b1;
    bus.cmd = 16'hFFFF;
    @(negedge clk);
    bus.wrt = 1'b0;
    chk("ret_done", 32'(bus.done), 32'd1);
    chk("ret_rd", 32'(bus.rd_data), 32'h3C3C);
    repeat (5) @(negedge clk);
    chk("ret_ss_idle", 32'(bus.SS_n), 32'd1);
    chk("ret_done_held", 32'(bus.done), 32'd1);

    // wrt re-pulsed at E+100 while busy
    dr0 = done_rises;
    send(16'h1062);
    repeat (99) @(negedge clk);
    bus.wrt = 1'b1;
    bus.cmd = 16'hFFFF;
    @(negedge clk);
    bus.wrt = 1'b0;
    wait_done(100, lat);
    chk("busy_lat", 32'(lat), 32'd521);
    chk("busy_rd", 32'(bus.rd_data), 32'h1062);
    repeat (20) @(negedge clk);
    chk("busy_one_done", 32'(done_rises - dr0), 32'd1);
    chk("busy_done", 32'(bus.done), 32'd1);

    // async reset mid-transfer, away from any clk edge
    send(16'hC3A5);
    repeat (299) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ss", 32'(bus.SS_n), 32'd1);
    chk("mid_rst_sclk", 32'(bus.SCLK), 32'd1);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_rd", 32'(bus.rd_data), 32'h0000);
    chk("mid_rst_mosi", 32'(bus.MOSI), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(16'h1460, 16'h1460, "post_rst");

    // done persistence
    repeat (1000) @(negedge clk);
    chk("persist_done", 32'(bus.done), 32'd1);
    chk("persist_rd", 32'(bus.rd_data), 32'h1460);
    send(16'h5555);
    wait_done(0, lat);
    chk("last_lat", 32'(lat), 32'd521);
    chk("last_rd", 32'(bus.rd_data), 32'h5555);

    chk("sclk_idle_high", 32'(idle_bad), 32'd0);
    chk("mosi_stable", 32'(mosi_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
